// File: rtl/sete_seg_dec.sv
// sete_seg_dec: reads back a multiplexed active-low 7-segment bus.
// Debounces each digit's pattern, then decodes it to a hex nibble.
module sete_seg_dec #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_i,
  output logic [4*NUM_DIGITS-1:0] Y_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    upd_o,
  output logic                    err_o
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] dig;
    logic [6:0]            seg;
  } smp_t;

  smp_t   s_q;
  smp_t   p_q;
  state_t st_q;
  state_t st_n;
  logic [7:0] cnt_q;
  logic [7:0] cnt_n;
  logic       cap;
  logic       one_hot;
  logic       same;
  logic       known;
  logic [3:0] nib;

  logic [4*NUM_DIGITS-1:0] y_n;
  logic [NUM_DIGITS-1:0]   valid_n;
  logic                    upd_n;
  logic                    err_n;

  // p_q lags s_q by one cycle so stability compares two registered samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= {dig_i, seg_i};
      p_q <= s_q;
    end
  end

  assign one_hot = $onehot(s_q.dig);
  assign same    = (s_q == p_q);

  always_comb begin
    known = 1'b1;
    nib   = 4'h0;
    case (s_q.seg)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    known = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    cap   = 1'b0;
    case (st_q)
      IDLE: begin
        if (one_hot) begin
          st_n  = COUNT;
          cnt_n = 8'd1;
        end
      end
      COUNT: begin
        if (!one_hot) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else if (same) begin
          cnt_n = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end else begin
          cnt_n = 8'd1;
        end
      end
      HOLD: begin
        if (!one_hot) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else if (!same) begin
          st_n  = COUNT;
          cnt_n = 8'd1;
        end
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
    // a run reaching its target captures on this edge and parks in HOLD
    if (st_n == COUNT && cnt_n == CNT_MAX) begin
      cap  = 1'b1;
      st_n = HOLD;
    end
  end

  always_comb begin
    y_n     = Y_o;
    valid_n = valid_o;
    upd_n   = 1'b0;
    err_n   = 1'b0;
    if (cap) begin
      if (s_q.seg == BLANK || known) begin
        upd_n = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (s_q.dig[k]) begin
            y_n[4*k +: 4] = (s_q.seg == BLANK) ? 4'h0 : nib;
            valid_n[k]    = (s_q.seg != BLANK);
          end
        end
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Y_o     <= '0;
      valid_o <= '0;
      upd_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      Y_o     <= y_n;
      valid_o <= valid_n;
      upd_o   <= upd_n;
      err_o   <= err_n;
    end
  end

endmodule

// File: tb/tb_sete_seg_dec.sv
// tb_sete_seg_dec: vectors, directed corners and random traffic
// checked every cycle against a run-length reference model.
module tb_sete_seg_dec;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] dig;
  logic [4*ND-1:0] y;
  logic [ND-1:0] vld;
  logic          upd;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int err_seen = 0;

  sete_seg_dec #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .seg_i(seg),
    .dig_i(dig),
    .Y_o(y),
    .valid_o(vld),
    .upd_o(upd),
    .err_o(err)
  );

  always #5 clk = ~clk;

  logic [6:0] tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a pattern is taken once its run of identical samples hits SC
  logic [4*ND-1:0] m_y;
  logic [ND-1:0]   m_v;
  logic            m_upd;
  logic            m_err;
  logic [ND+6:0]   m_s;
  int              m_run;

  task automatic model_capture();
    int k;
    int v;
    k = 0;
    v = -1;
    for (int i = 0; i < ND; i++) if (m_s[7+i]) k = i;
    for (int i = 0; i < 16; i++) if (tab[i] == m_s[6:0]) v = i;
    if (m_s[6:0] == 7'h7F) begin
      m_y[4*k +: 4] = 4'h0;
      m_v[k] = 1'b0;
      m_upd = 1'b1;
    end else if (v >= 0) begin
      m_y[4*k +: 4] = 4'(v);
      m_v[k] = 1'b1;
      m_upd = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y = '0;
      m_v = '0;
      m_upd = 1'b0;
      m_err = 1'b0;
      m_s = '0;
      m_run = 0;
    end else begin
      m_upd = 1'b0;
      m_err = 1'b0;
      if ($countones(m_s[ND+6:7]) == 1 && m_run == SC)
        model_capture();
      if ({dig, seg} == m_s) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_s = {dig, seg};
        m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc Y", y, m_y);
      check("cyc valid", vld, m_v);
      check("cyc upd", upd, m_upd);
      check("cyc err", err, m_err);
      if (upd) upd_seen++;
      if (err) err_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic hold(input logic [ND-1:0] d, input logic [6:0] s,
                      input int n);
    dig = d;
    seg = s;
    repeat (n) step();
  endtask

  typedef struct {
    logic [ND-1:0] d;
    logic [6:0]    s;
    logic [3:0]    nib;
    logic          v;
    int            n_upd;
    int            n_err;
  } vec_t;

  vec_t vt [18];
  int   u0;
  int   e0;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'b0001, 7'b1000000, 4'h0, 1'b1, 1, 0};
    vt[1]  = '{4'b0010, 7'b1111001, 4'h1, 1'b1, 1, 0};
    vt[2]  = '{4'b0100, 7'b0100100, 4'h2, 1'b1, 1, 0};
    vt[3]  = '{4'b1000, 7'b0110000, 4'h3, 1'b1, 1, 0};
    vt[4]  = '{4'b0001, 7'b0011001, 4'h4, 1'b1, 1, 0};
    vt[5]  = '{4'b0010, 7'b0010010, 4'h5, 1'b1, 1, 0};
    vt[6]  = '{4'b0100, 7'b0000010, 4'h6, 1'b1, 1, 0};
    vt[7]  = '{4'b1000, 7'b1111000, 4'h7, 1'b1, 1, 0};
    vt[8]  = '{4'b0001, 7'b0000000, 4'h8, 1'b1, 1, 0};
    vt[9]  = '{4'b0010, 7'b0010000, 4'h9, 1'b1, 1, 0};
    vt[10] = '{4'b0100, 7'b0001000, 4'hA, 1'b1, 1, 0};
    vt[11] = '{4'b1000, 7'b0000011, 4'hB, 1'b1, 1, 0};
    vt[12] = '{4'b0001, 7'b1000110, 4'hC, 1'b1, 1, 0};
    vt[13] = '{4'b0010, 7'b0100001, 4'hD, 1'b1, 1, 0};
    vt[14] = '{4'b0100, 7'b0000110, 4'hE, 1'b1, 1, 0};
    vt[15] = '{4'b1000, 7'b0001110, 4'hF, 1'b1, 1, 0};
    vt[16] = '{4'b0001, 7'b1010101, 4'hC, 1'b1, 0, 1};
    vt[17] = '{4'b0010, 7'b1111111, 4'h0, 1'b0, 1, 0};

    rst = 1'b1;
    dig = '0;
    seg = 7'h7F;
    repeat (3) @(posedge clk);
    #6;
    rst = 1'b0;
    check("reset Y", y, 0);
    check("reset valid", vld, 0);
    check("reset upd", upd, 0);
    check("reset err", err, 0);

    u0 = upd_seen;
    hold(4'b0001, 7'b0110000, SC);
    check("t1 early", upd_seen - u0, 0);
    step();
    check("t1 pulse", upd_seen - u0, 1);
    check("t1 nib", y[3:0], 4'h3);
    check("t1 valid", vld, 4'b0001);
    repeat (5) step();
    check("t1 held", upd_seen - u0, 1);

    for (int i = 0; i < 18; i++) begin
      int k;
      k = 0;
      for (int j = 0; j < ND; j++) if (vt[i].d[j]) k = j;
      u0 = upd_seen;
      e0 = err_seen;
      hold(vt[i].d, vt[i].s, SC + 2);
      check($sformatf("vec%0d nib", i), y[4*k +: 4], vt[i].nib);
      check($sformatf("vec%0d valid", i), vld[k], vt[i].v);
      check($sformatf("vec%0d upd", i), upd_seen - u0, vt[i].n_upd);
      check($sformatf("vec%0d err", i), err_seen - e0, vt[i].n_err);
    end

    u0 = upd_seen;
    hold(4'b0001, 7'b0001110, 6);
    hold(4'b0010, 7'b0000011, 6);
    hold(4'b0100, 7'b1111001, 6);
    hold(4'b1000, 7'b1000000, 6);
    check("scan Y", y, 16'h01BF);
    check("scan valid", vld, 4'b1111);
    check("scan upd", upd_seen - u0, 4);

    u0 = upd_seen;
    for (int i = 0; i < 10; i++)
      hold(4'b0001, (i % 2 == 0) ? 7'b0100100 : 7'b0110000, 2);
    check("toggle upd", upd_seen - u0, 0);
    hold(4'b0001, 7'b0100100, SC);
    check("settle early", upd_seen - u0, 0);
    step();
    check("settle upd", upd_seen - u0, 1);
    check("settle nib", y[3:0], 4'h2);

    hold(4'b0100, 7'b0010000, 6);
    u0 = upd_seen;
    e0 = err_seen;
    hold(4'b0100, 7'b1010101, 6);
    check("bad err", err_seen - e0, 1);
    check("bad upd", upd_seen - u0, 0);
    check("bad nib", y[11:8], 4'h9);
    check("bad valid", vld[2], 1'b1);

    hold(4'b0010, 7'b0001000, 6);
    u0 = upd_seen;
    hold(4'b0010, 7'b1111111, 6);
    check("blank upd", upd_seen - u0, 1);
    check("blank valid", vld[1], 1'b0);
    check("blank nib", y[7:4], 4'h0);
    u0 = upd_seen;
    e0 = err_seen;
    hold(4'b0011, 7'($urandom), 8);
    check("multi upd", upd_seen - u0, 0);
    check("multi err", err_seen - e0, 0);

    hold(4'b0100, 7'b0011001, SC - 1 + 1);
    rst = 1'b1;
    #1;
    check("async Y", y, 0);
    check("async valid", vld, 0);
    check("async upd", upd, 0);
    check("async err", err, 0);
    step();
    rst = 1'b0;
    u0 = upd_seen;
    hold(4'b0100, 7'b0011001, SC);
    check("resettle early", upd_seen - u0, 0);
    step();
    check("resettle upd", upd_seen - u0, 1);
    check("resettle Y", y, 16'h0400);
    check("resettle valid", vld, 4'b0100);

    for (int i = 0; i < 500; i++) begin
      logic [ND-1:0] d;
      logic [6:0]    s;
      int            r;
      d = '0;
      d[$urandom_range(0, ND-1)] = 1'b1;
      r = $urandom_range(0, 9);
      if (r == 0) d = '0;
      else if (r == 1) d = ND'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6) s = tab[$urandom_range(0, 15)];
      else if (r < 8) s = 7'h7F;
      else s = 7'($urandom);
      hold(d, s, $urandom_range(1, SC + 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
